// File: rtl/sequence_controller_pkg.sv
// Gate-array timing package: default phase masks for an 8-stage sequencer and the
// Johnson-state to phase-index decode shared by the sequencer and the strobe decode.
package sequence_controller_pkg;

  localparam int STAGES_DEF  = 8;
  localparam int P           = 2 * STAGES_DEF;
  localparam int MAX_STAGES  = 32;
  localparam int PHASE_W_MAX = 6;

  localparam logic [P-1:0] PHI_MASK_DEF   = 16'hCCCC;
  localparam logic [P-1:0] RAS_MASK_DEF   = 16'h0186;
  localparam logic [P-1:0] CPU_MASK_DEF   = 16'h00FC;
  localparam logic [P-1:0] CCLK_MASK_DEF  = 16'hC007;
  localparam logic [P-1:0] MWE_MASK_DEF   = 16'h01C0;
  localparam logic [P-1:0] E244_MASK_DEF  = 16'h07F0;
  localparam logic [P-1:0] READY_MASK_DEF = 16'h0070;

  typedef struct packed {
    logic                   legal;
    logic [PHASE_W_MAX-1:0] phase;
  } phase_dec_t;

  // Phase p has S[i]=1 exactly for p in [i+1, i+stages]; anything else is illegal
  // and reports phase 0.
  function automatic phase_dec_t johnson_to_phase(input logic [MAX_STAGES-1:0] s,
                                                  input int stages);
    phase_dec_t            res;
    logic [MAX_STAGES-1:0] pat;
    res = '0;
    for (int p = 0; p < 2 * MAX_STAGES; p++) begin
      if (p < 2 * stages) begin
        pat = '0;
        for (int i = 0; i < MAX_STAGES; i++) begin
          pat[i] = (i < stages) && (p >= i + 1) && (p <= i + stages);
        end
        if (s == pat) begin
          res.legal = 1'b1;
          res.phase = PHASE_W_MAX'(p);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sequence_controller_johnson_seq.sv
// Johnson phase sequencer with illegal-state recovery and bounded hold at HOLD_PHASE.
// Latency: S updates every posedge; PHASE/legal combinational from S; no backpressure beyond hold_req_i.
module johnson_seq
  import sequence_controller_pkg::*;
#(
  parameter int STAGES     = STAGES_DEF,
  parameter int HOLD_PHASE = 7,
  parameter int MAX_HOLD   = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          hold_req_i,
  output logic [STAGES-1:0]             s_o,
  output logic [$clog2(2*STAGES)-1:0]   phase_o,
  output logic                          legal_o,
  output logic                          holding_o
);

  localparam int PW  = $clog2(2 * STAGES);
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  logic [STAGES-1:0] s_q, s_d;
  logic [HCW-1:0]    hold_cnt_q, hold_cnt_d;
  logic              holding_q, holding_d;
  phase_dec_t        dec;
  logic [PW-1:0]     phase;
  logic              legal;

  assign dec   = johnson_to_phase(MAX_STAGES'(s_q), STAGES);
  assign legal = dec.legal;
  assign phase = PW'(dec.phase);

  // Illegal states collapse to S=0 ahead of any hold decision.
  always_comb begin
    s_d        = s_q;
    hold_cnt_d = '0;
    holding_d  = 1'b0;
    if (!legal) begin
      s_d = '0;
    end else if ((phase == PW'(HOLD_PHASE)) && hold_req_i &&
                 (int'(hold_cnt_q) < MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
      holding_d  = 1'b1;
    end else begin
      s_d = {s_q[STAGES-2:0], ~s_q[STAGES-1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s_q        <= '0;
      hold_cnt_q <= '0;
      holding_q  <= 1'b0;
    end else begin
      s_q        <= s_d;
      hold_cnt_q <= hold_cnt_d;
      holding_q  <= holding_d;
    end
  end

  assign s_o       = s_q;
  assign phase_o   = phase;
  assign legal_o   = legal;
  assign holding_o = holding_q;

endmodule

// File: rtl/sequence_controller.sv
// Gate-array timing root: Johnson sequencer plus per-output phase-mask strobe decode.
// Latency: strobes lag phase by one posedge, CASAD_n/READY a further half cycle; stalls only via HOLD_REQ.
module sequence_controller
  import sequence_controller_pkg::*;
#(
  parameter int                  STAGES     = STAGES_DEF,
  parameter logic [2*STAGES-1:0] PHI_MASK   = PHI_MASK_DEF,
  parameter logic [2*STAGES-1:0] RAS_MASK   = RAS_MASK_DEF,
  parameter logic [2*STAGES-1:0] CPU_MASK   = CPU_MASK_DEF,
  parameter logic [2*STAGES-1:0] CCLK_MASK  = CCLK_MASK_DEF,
  parameter logic [2*STAGES-1:0] MWE_MASK   = MWE_MASK_DEF,
  parameter logic [2*STAGES-1:0] E244_MASK  = E244_MASK_DEF,
  parameter logic [2*STAGES-1:0] READY_MASK = READY_MASK_DEF,
  parameter int                  HOLD_PHASE = 7,
  parameter int                  MAX_HOLD   = 3
) (
  input  logic                        CLK_n,
  input  logic                        RESET_n,
  input  logic                        RD_n,
  input  logic                        IORQ_n,
  input  logic                        HOLD_REQ,
  output logic [STAGES-1:0]           S,
  output logic [$clog2(2*STAGES)-1:0] PHASE,
  output logic                        SYNC,
  output logic                        HOLDING,
  output logic                        PHI_n,
  output logic                        RAS_n,
  output logic                        CPU_n,
  output logic                        CCLK,
  output logic                        MWE_n,
  output logic                        s244E_n,
  output logic                        CASAD_n,
  output logic                        READY
);

  localparam int PW = $clog2(2 * STAGES);

  logic [PW-1:0] seq_phase;
  logic [PW-1:0] p;
  logic          seq_legal;

  logic phi_q, phi_d;
  logic ras_q, ras_d;
  logic cpu_q, cpu_d;
  logic cclk_q, cclk_d;
  logic mwe_q, mwe_d;
  logic e244_q, e244_d;
  logic sync_q, sync_d;
  logic casad_q, ready_q;

  johnson_seq #(
    .STAGES     (STAGES),
    .HOLD_PHASE (HOLD_PHASE),
    .MAX_HOLD   (MAX_HOLD)
  ) u_seq (
    .clk_i      (CLK_n),
    .rst_ni     (RESET_n),
    .hold_req_i (HOLD_REQ),
    .s_o        (S),
    .phase_o    (seq_phase),
    .legal_o    (seq_legal),
    .holding_o  (HOLDING)
  );

  assign p = seq_legal ? seq_phase : '0;

  // A held phase re-decodes to the same values, so strobes freeze naturally.
  always_comb begin
    phi_d  = PHI_MASK[p];
    ras_d  = RAS_MASK[p];
    cpu_d  = ~CPU_MASK[p];
    cclk_d = CCLK_MASK[p];
    mwe_d  = ~(MWE_MASK[p] & RD_n);
    e244_d = ~(E244_MASK[p] & ~IORQ_n);
    sync_d = (p == '0);
  end

  always_ff @(posedge CLK_n) begin
    if (!RESET_n) begin
      phi_q  <= 1'b1;
      ras_q  <= 1'b1;
      cpu_q  <= 1'b1;
      cclk_q <= 1'b0;
      mwe_q  <= 1'b1;
      e244_q <= 1'b1;
      sync_q <= 1'b0;
    end else begin
      phi_q  <= phi_d;
      ras_q  <= ras_d;
      cpu_q  <= cpu_d;
      cclk_q <= cclk_d;
      mwe_q  <= mwe_d;
      e244_q <= e244_d;
      sync_q <= sync_d;
    end
  end

  // READY latches on its mask phases and is kept alive only while RAS_n is low.
  always_ff @(negedge CLK_n) begin
    if (!RESET_n) begin
      casad_q <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      casad_q <= ras_q;
      ready_q <= (~ras_q & ready_q) | READY_MASK[p];
    end
  end

  assign PHASE   = seq_phase;
  assign SYNC    = sync_q;
  assign PHI_n   = phi_q;
  assign RAS_n   = ras_q;
  assign CPU_n   = cpu_q;
  assign CCLK    = cclk_q;
  assign MWE_n   = mwe_q;
  assign s244E_n = e244_q;
  assign CASAD_n = casad_q;
  assign READY   = ready_q;

endmodule

// File: tb/tb_sequence_controller.sv
// Directed bench for sequence_controller with default 8-stage masks.
module tb_sequence_controller;

  logic       CLK_n = 1'b0;
  logic       RESET_n, RD_n, IORQ_n, HOLD_REQ;
  logic [7:0] S;
  logic [3:0] PHASE;
  logic       SYNC, HOLDING, PHI_n, RAS_n, CPU_n, CCLK, MWE_n, s244E_n, CASAD_n, READY;

  int checks   = 0;
  int failures = 0;
  int ph, prev;

  sequence_controller dut (
    .CLK_n   (CLK_n),   .RESET_n (RESET_n), .RD_n    (RD_n),    .IORQ_n (IORQ_n),
    .HOLD_REQ(HOLD_REQ), .S      (S),       .PHASE   (PHASE),   .SYNC   (SYNC),
    .HOLDING (HOLDING), .PHI_n   (PHI_n),   .RAS_n   (RAS_n),   .CPU_n  (CPU_n),
    .CCLK    (CCLK),    .MWE_n   (MWE_n),   .s244E_n (s244E_n), .CASAD_n(CASAD_n),
    .READY   (READY)
  );

  always #5 CLK_n = ~CLK_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK_n);
    #1;
  endtask

  task automatic tickn;
    @(negedge CLK_n);
    #1;
  endtask

  // Hand-expanded default masks, indexed by the phase before the edge.
  function automatic logic exp_phi(input int p);
    return (p % 4) >= 2;
  endfunction
  function automatic logic exp_ras(input int p);
    return (p == 1) || (p == 2) || (p == 7) || (p == 8);
  endfunction
  function automatic logic exp_cpu_n(input int p);
    return !((p >= 2) && (p <= 7));
  endfunction
  function automatic logic exp_cclk(input int p);
    return (p <= 2) || (p >= 14);
  endfunction

  task automatic chk_strobes(input int p, input logic rd, input logic iorq);
    chk1($sformatf("PHI_n@p%0d", p), PHI_n, exp_phi(p));
    chk1($sformatf("RAS_n@p%0d", p), RAS_n, exp_ras(p));
    chk1($sformatf("CPU_n@p%0d", p), CPU_n, exp_cpu_n(p));
    chk1($sformatf("CCLK@p%0d", p), CCLK, exp_cclk(p));
    chk1($sformatf("MWE_n@p%0d", p), MWE_n, !(rd && (p >= 6) && (p <= 8)));
    chk1($sformatf("s244E_n@p%0d", p), s244E_n, !(!iorq && (p >= 4) && (p <= 10)));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_S"}, 32'(S), 0);
    chk({tag, "_PHASE"}, 32'(PHASE), 0);
    chk({tag, "_hold_cnt"}, 32'(dut.u_seq.hold_cnt_q), 0);
    chk1({tag, "_SYNC"}, SYNC, 1'b0);
    chk1({tag, "_HOLDING"}, HOLDING, 1'b0);
    chk1({tag, "_PHI_n"}, PHI_n, 1'b1);
    chk1({tag, "_RAS_n"}, RAS_n, 1'b1);
    chk1({tag, "_CPU_n"}, CPU_n, 1'b1);
    chk1({tag, "_CCLK"}, CCLK, 1'b0);
    chk1({tag, "_MWE_n"}, MWE_n, 1'b1);
    chk1({tag, "_s244E_n"}, s244E_n, 1'b1);
  endtask

  initial begin
    RESET_n = 1'b0; RD_n = 1'b0; IORQ_n = 1'b1; HOLD_REQ = 1'b0;
    repeat (3) tick;
    chk_reset_outputs("rst");
    chk1("rst_CASAD_n", CASAD_n, 1'b1);
    chk1("rst_READY", READY, 1'b0);

    // First edge after release leaves phase 0.
    RESET_n = 1'b1;
    tick;
    chk("rel_S", 32'(S), 32'h01);
    chk("rel_PHASE", 32'(PHASE), 1);
    chk1("rel_SYNC", SYNC, 1'b1);
    chk_strobes(0, 1'b0, 1'b1);
    ph = 1;

    // Free run, RD_n=0/IORQ_n=1: MWE_n and s244E_n stay high.
    for (int i = 0; i < 16; i++) begin
      prev = ph;
      tick;
      ph = (ph + 1) % 16;
      chk("run_PHASE", 32'(PHASE), ph);
      chk1("run_SYNC", SYNC, ph == 1);
      chk_strobes(prev, 1'b0, 1'b1);
    end

    // Write and buffer-enable windows.
    RD_n = 1'b1; IORQ_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      prev = ph;
      tick;
      ph = (ph + 1) % 16;
      chk("io_PHASE", 32'(PHASE), ph);
      chk_strobes(prev, 1'b1, 1'b0);
    end
    RD_n = 1'b0; IORQ_n = 1'b1;

    // READY / CASAD_n on falling edges.
    for (int i = 0; i < 16; i++) begin
      prev = ph;
      tick;
      ph = (ph + 1) % 16;
      tickn;
      chk1($sformatf("READY@p%0d", ph), READY, (ph >= 4) && (ph <= 7));
      chk1($sformatf("CASAD_n@p%0d", ph), CASAD_n, exp_ras(prev));
    end

    // Bounded hold: HOLD_REQ held high for a whole 19-cycle period.
    HOLD_REQ = 1'b1; RD_n = 1'b1;
    for (int j = 1; j <= 19; j++) begin
      prev = ph;
      tick;
      ph = (j <= 6) ? j + 1 : ((j <= 9) ? 7 : (j - 2) % 16);
      chk($sformatf("hold_PHASE@%0d", j), 32'(PHASE), ph);
      chk1($sformatf("hold_HOLDING@%0d", j), HOLDING, (j >= 7) && (j <= 9));
      chk1($sformatf("hold_SYNC@%0d", j), SYNC, j == 19);
      chk_strobes(prev, 1'b1, 1'b1);
    end
    HOLD_REQ = 1'b0; RD_n = 1'b0;

    // Single-cycle hold at phase 7; a request at phase 3 is ignored.
    for (int j = 1; j <= 17; j++) begin
      prev = ph;
      HOLD_REQ = (j == 7) || (j == 3);
      tick;
      ph = (j <= 6) ? j + 1 : ((j == 7) ? 7 : j % 16);
      chk($sformatf("short_PHASE@%0d", j), 32'(PHASE), ph);
      chk1($sformatf("short_HOLDING@%0d", j), HOLDING, j == 7);
      chk1($sformatf("short_SYNC@%0d", j), SYNC, j == 17);
      chk_strobes(prev, 1'b0, 1'b1);
    end
    HOLD_REQ = 1'b0;

    // Illegal state recovery.
    force dut.u_seq.s_q = 8'b0101_0000;
    #1;
    chk("ill_S", 32'(S), 32'h50);
    chk("ill_PHASE", 32'(PHASE), 0);
    release dut.u_seq.s_q;
    tick;
    chk("ill_next_S", 32'(S), 32'h00);
    chk1("ill_next_SYNC", SYNC, 1'b1);
    tick;
    chk("ill_rec_PHASE", 32'(PHASE), 1);
    chk("ill_rec_S", 32'(S), 32'h01);
    chk1("ill_rec_SYNC", SYNC, 1'b1);

    // Reset during the second hold cycle.
    HOLD_REQ = 1'b1;
    repeat (6) tick;
    chk("mh_PHASE", 32'(PHASE), 7);
    tick;
    chk1("mh_hold1", HOLDING, 1'b1);
    tick;
    chk1("mh_hold2", HOLDING, 1'b1);
    RESET_n = 1'b0;
    tick;
    chk_reset_outputs("mh");
    tickn;
    chk1("mh_CASAD_n", CASAD_n, 1'b1);
    chk1("mh_READY", READY, 1'b0);
    RESET_n = 1'b1;
    tick;
    chk("mh_rel_S", 32'(S), 32'h01);
    chk1("mh_rel_SYNC", SYNC, 1'b1);
    repeat (6) tick;
    chk("mh_rel_PHASE7", 32'(PHASE), 7);
    for (int j = 1; j <= 3; j++) begin
      tick;
      chk1($sformatf("mh_rehold@%0d", j), HOLDING, 1'b1);
      chk($sformatf("mh_rehold_PHASE@%0d", j), 32'(PHASE), 7);
    end
    tick;
    chk1("mh_release_HOLDING", HOLDING, 1'b0);
    chk("mh_release_PHASE", 32'(PHASE), 8);
    HOLD_REQ = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
